// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - requestor and memory bus bundle for mem_arbiter
// Ports carried:
//   req_val/req_rdy/req_addr/req_fcn/req_wdata/req_wmask  per-port request channel
//   resp_val/resp_rdata                                    per-port response, shared data
//   mem_req_val/mem_req_rdy/mem_req_addr/mem_req_fcn/
//   mem_req_wdata/mem_req_wmask                            forwarded memory request
//   mem_resp_val/mem_resp_rdata                            memory response
// Modports: slave = arbiter view, master = requestors plus memory model view.
interface mem_arbiter_if #(
  parameter int NPORT = 2,
  parameter int AW    = 32,
  parameter int DW    = 32
);
  logic [NPORT-1:0]        req_val;
  logic [NPORT-1:0]        req_rdy;
  logic [NPORT*AW-1:0]     req_addr;
  logic [NPORT-1:0]        req_fcn;
  logic [NPORT*DW-1:0]     req_wdata;
  logic [NPORT*DW/8-1:0]   req_wmask;
  logic [NPORT-1:0]        resp_val;
  logic [DW-1:0]           resp_rdata;
  logic                    mem_req_val;
  logic                    mem_req_rdy;
  logic [AW-1:0]           mem_req_addr;
  logic                    mem_req_fcn;
  logic [DW-1:0]           mem_req_wdata;
  logic [DW/8-1:0]         mem_req_wmask;
  logic                    mem_resp_val;
  logic [DW-1:0]           mem_resp_rdata;

  modport slave (
    input  req_val, req_addr, req_fcn, req_wdata, req_wmask,
    input  mem_req_rdy, mem_resp_val, mem_resp_rdata,
    output req_rdy, resp_val, resp_rdata,
    output mem_req_val, mem_req_addr, mem_req_fcn, mem_req_wdata, mem_req_wmask
  );

  modport master (
    output req_val, req_addr, req_fcn, req_wdata, req_wmask,
    output mem_req_rdy, mem_resp_val, mem_resp_rdata,
    input  req_rdy, resp_val, resp_rdata,
    input  mem_req_val, mem_req_addr, mem_req_fcn, mem_req_wdata, mem_req_wmask
  );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin N-port memory arbiter with in-order response routing
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-low reset
//   bus          mem_arbiter_if.slave: requestor channels and memory channel
//   outstanding  number of accepted requests still awaiting a response
//   err_orphan   sticky: a memory response arrived with nothing outstanding
module mem_arbiter #(
  parameter int NPORT = 2,
  parameter int AW    = 32,
  parameter int DW    = 32,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  mem_arbiter_if.slave           bus,
  output logic [$clog2(DEPTH):0] outstanding,
  output logic                   err_orphan
);

  localparam int PW  = $clog2(NPORT);
  localparam int FAW = $clog2(DEPTH);
  localparam int CW  = FAW + 1;
  localparam logic [PW:0]   NPL    = (PW+1)'(NPORT);
  localparam logic [CW-1:0] DEPTHL = CW'(DEPTH);

  logic [PW-1:0]  ptr;
  logic [PW-1:0]  g;
  logic [PW-1:0]  ptr_nxt;
  logic [PW-1:0]  head;
  logic [PW-1:0]  tags [DEPTH];
  logic [FAW-1:0] wptr;
  logic [FAW-1:0] rptr;
  logic [CW-1:0]  count;
  logic           full;
  logic           empty;
  logic           push;
  logic           pop;
  logic           orphan;
  logic           found;
  logic [PW:0]    sum;
  logic [PW:0]    nsum;

  logic [AW-1:0]   addr_a  [NPORT];
  logic [DW-1:0]   wdata_a [NPORT];
  logic [DW/8-1:0] wmask_a [NPORT];

  for (genvar i = 0; i < NPORT; i++) begin : g_unpack
    assign addr_a[i]  = bus.req_addr[i*AW +: AW];
    assign wdata_a[i] = bus.req_wdata[i*DW +: DW];
    assign wmask_a[i] = bus.req_wmask[i*(DW/8) +: DW/8];
  end

  // Full is judged on the registered count, so a same-cycle pop never frees a slot early.
  assign full        = (count == DEPTHL);
  assign empty       = (count == '0);
  assign outstanding = count;

  // Round-robin search starting at ptr, wrapping modulo NPORT.
  always_comb begin
    g     = ptr;
    found = 1'b0;
    sum   = '0;
    for (int k = 0; k < NPORT; k++) begin
      sum = {1'b0, ptr} + (PW+1)'(k);
      if (sum >= NPL) sum = sum - NPL;
      if (!found && bus.req_val[sum[PW-1:0]]) begin
        g     = sum[PW-1:0];
        found = 1'b1;
      end
    end
  end

  always_comb begin
    nsum    = {1'b0, g} + (PW+1)'(1);
    ptr_nxt = (nsum == NPL) ? '0 : nsum[PW-1:0];
  end

  assign bus.mem_req_val   = rst && (|bus.req_val) && !full;
  assign bus.mem_req_addr  = addr_a[g];
  assign bus.mem_req_fcn   = bus.req_fcn[g];
  assign bus.mem_req_wdata = wdata_a[g];
  assign bus.mem_req_wmask = wmask_a[g];

  always_comb begin
    bus.req_rdy = '0;
    if (rst && bus.mem_req_rdy && !full && bus.req_val[g]) bus.req_rdy[g] = 1'b1;
  end

  assign push   = bus.mem_req_val && bus.mem_req_rdy;
  assign head   = tags[rptr];
  assign pop    = rst && bus.mem_resp_val && !empty;
  assign orphan = rst && bus.mem_resp_val && empty;

  // Responses are routed to the oldest tag with no added latency.
  always_comb begin
    bus.resp_val = '0;
    if (pop) bus.resp_val[head] = 1'b1;
  end

  assign bus.resp_rdata = bus.mem_resp_rdata;

  // Tag storage needs no reset: entries are only read behind a valid count.
  always_ff @(posedge clk) begin
    if (push) tags[wptr] <= g;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr        <= '0;
      wptr       <= '0;
      rptr       <= '0;
      count      <= '0;
      err_orphan <= 1'b0;
    end else begin
      if (push) begin
        wptr <= wptr + FAW'(1);
        ptr  <= ptr_nxt;
      end
      if (pop) rptr <= rptr + FAW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (orphan) err_orphan <= 1'b1;
    end
  end

endmodule
